pulse_train_tx: RTL and testbench

- Transmit side of the single-bit event line. Accepts single-cycle event strobes (trig) and drives a level line (pulse_out) with one clean pulse per event.
- Each pulse has a guaranteed minimum high width and minimum low gap, so a receiver in another clock domain (2-FF synchronizer plus rising-edge detector) sees exactly one edge per event.
- Bursts of events are queued in a saturating pending counter. Used for the vibration-motor/LED/interrupt lines toward the HPS and external pins.

---
 rtl/pulse_tx_pkg.sv | 14 +
 rtl/sat_updown_counter.sv | 44 ++++
 rtl/pulse_train_tx.sv | 121 ++++++++++++
 tb/tb_pulse_train_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_tx_pkg.sv
// Shared types and limits for the pulse_train_tx event-line transmitter.
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam int CNT_W      = 8;
  localparam int MIN_CYCLES = 2;
  localparam int MAX_CYCLES = 255;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter holding the queued-event count; flags a dropped increment.
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_drop
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] count_q, count_d;
  logic         drop_q, drop_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    count_d = count_q;
    drop_d  = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX_COUNT) drop_d = 1'b1;
      else                      count_d = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign count    = count_q;
  assign sat_drop = drop_q;

endmodule

// File: rtl/pulse_train_tx.sv
// Event strobes -> one clean pulse each, with guaranteed high width and low gap.
// Optional done strobe on queue drain when PULSE_TRAIN_TX_DONE_EN is defined.
module pulse_train_tx
  import pulse_tx_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
`ifdef PULSE_TRAIN_TX_DONE_EN
  ,
  output logic              done
`endif
);

  if (HIGH_CYCLES < MIN_CYCLES || HIGH_CYCLES > MAX_CYCLES ||
      GAP_CYCLES < MIN_CYCLES || GAP_CYCLES > MAX_CYCLES || PEND_W < 1) begin : g_bad_param
    $error("pulse_train_tx: HIGH_CYCLES/GAP_CYCLES must be 2..255 and PEND_W >= 1");
  end

  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pulse_q;
  logic               busy_q;
  logic [PEND_W-1:0]  pend_cnt;
  logic               sat_drop;
  logic               pend_nz, last_gap, start_idle, start_direct, inc, dec;

  // A trig that starts a pulse itself never enters the queue; a queued one leaves it.
  assign pend_nz      = |pend_cnt;
  assign last_gap     = (state_q == GAP) && (cnt_q == GAP_LAST);
  assign start_idle   = (state_q == IDLE) && trig;
  assign start_direct = last_gap && !pend_nz && trig;
  assign dec          = last_gap && pend_nz;
  assign inc          = trig && !(start_idle || start_direct);

  sat_updown_counter #(.W(PEND_W)) u_pending (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .dec      (dec),
    .count    (pend_cnt),
    .sat_drop (sat_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (pend_nz || trig) begin
              state_q <= HIGH;
              pulse_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_TRAIN_TX_DONE_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= last_gap && !pend_nz && !trig;
  end

  assign done = done_q;
`endif

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_cnt;
  assign overflow  = sat_drop;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Random + directed stimulus against an event-list reference model; scoreboard on pulse starts.
module tb_pulse_train_tx;

  localparam int H    = 4;
  localparam int G    = 4;
  localparam int PW   = 2;
  localparam int P    = H + G;
  localparam int MAXP = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trig = 1'b0;
  logic          pulse_out, busy, overflow;
  logic [PW-1:0] pending;
`ifdef PULSE_TRAIN_TX_DONE_EN
  logic          done;
`endif

  always #5 clk = ~clk;

  pulse_train_tx #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
`ifdef PULSE_TRAIN_TX_DONE_EN
    ,
    .done      (done)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b0;
  logic prev_pulse = 1'b0;

  // Accepted events: trig edge and start edge; dropped trig edges; expected pulse starts.
  int acc_c[$];
  int acc_s[$];
  int drop_c[$];
  int exp_start_q[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  function automatic void clear_model();
    acc_c.delete();
    acc_s.delete();
    drop_c.delete();
    exp_start_q.delete();
  endfunction

  // Pulses are paced one period apart in arrival order; a trig that would have to
  // wait while MAXP events are already waiting is dropped.
  function automatic void model_add(int c);
    int s, waiting;
    s = (acc_s.size() == 0 || acc_s[$] + P <= c) ? c : acc_s[$] + P;
    if (s != c) begin
      waiting = 0;
      foreach (acc_s[i]) if (acc_s[i] > c) waiting++;
      if (waiting >= MAXP) begin
        drop_c.push_back(c);
        return;
      end
    end
    acc_c.push_back(c);
    acc_s.push_back(s);
    exp_start_q.push_back(s);
  endfunction

  function automatic bit exp_pulse(int e);
    foreach (acc_s[i]) if (acc_s[i] <= e && e < acc_s[i] + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_busy(int e);
    foreach (acc_s[i]) if (acc_s[i] <= e && e < acc_s[i] + P) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_pend(int e);
    int n = 0;
    foreach (acc_s[i]) if (acc_c[i] <= e && acc_s[i] > e) n++;
    return n;
  endfunction

  function automatic bit exp_ovf(int e);
    foreach (drop_c[i]) if (drop_c[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_done(int e);
    bit hit = 1'b0;
    foreach (acc_s[i]) begin
      if (acc_s[i] == e) return 1'b0;
      if (acc_s[i] + P == e) hit = 1'b1;
    end
    return hit;
  endfunction

  always @(negedge clk) begin
    int s;
    if (mon_en) begin
      check("pulse_out", 32'(pulse_out), 32'(exp_pulse(edge_n)));
      check("busy",      32'(busy),      32'(exp_busy(edge_n)));
      check("pending",   32'(pending),   32'(exp_pend(edge_n)));
      check("overflow",  32'(overflow),  32'(exp_ovf(edge_n)));
`ifdef PULSE_TRAIN_TX_DONE_EN
      check("done",      32'(done),      32'(exp_done(edge_n)));
`endif
      if (pulse_out === 1'b1 && prev_pulse !== 1'b1) begin
        if (exp_start_q.size() == 0) begin
          check("unexpected_pulse_start", 32'(edge_n), 32'hFFFF_FFFF);
        end else begin
          s = exp_start_q.pop_front();
          check("pulse_start_edge", 32'(edge_n), 32'(s));
        end
      end
    end
    prev_pulse = pulse_out;
  end

  // Called at posedge+2; the trig set here is sampled at the next edge.
  task automatic step(bit t);
    trig = t;
    if (t) model_add(edge_n + 1);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    trig  = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    #1;
    repeat (n - 1) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int tgt;
    tgt = (acc_s.size() > 0) ? acc_s[$] + P + 3 : edge_n + 3;
    if (tgt < edge_n + 3) tgt = edge_n + 3;
    while (edge_n < tgt) step(1'b0);
  endtask

  initial begin
    int dens;
    reset = 1'b1;
    trig  = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    mon_en = 1'b1;
    #1;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;

    // Single event after idle cycles.
    repeat (6) step(1'b0);
    step(1'b1);
    wait_idle();

    // Burst of three.
    repeat (3) step(1'b1);
    wait_idle();

    // pending==1 with a trig on the last gap cycle: inc and dec cancel.
    step(1'b1);
    step(1'b1);
    repeat (P - 2) step(1'b0);
    step(1'b1);
    wait_idle();

    // Trig on the last gap cycle with nothing pending restarts directly.
    step(1'b1);
    repeat (P - 1) step(1'b0);
    step(1'b1);
    wait_idle();

    // Saturation: trig held for eight cycles.
    repeat (8) step(1'b1);
    wait_idle();

    // Reset mid-pulse with two events pending, then a normal pulse.
    repeat (3) step(1'b1);
    step(1'b0);
    do_reset(1);
    repeat (3) step(1'b0);
    step(1'b1);
    wait_idle();

    // Randomized traffic with varying density and occasional resets.
    dens = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) dens = int'($urandom_range(5, 95));
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
      else step($urandom_range(0, 99) < dens);
    end
    wait_idle();

    check("pulses_outstanding", 32'(exp_start_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
